// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: operation
// encodings, FSM state type and the default operand width.
package hilo_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/hilo_iter.sv
// One radix-2 iteration on magnitudes: shift-add for multiply, restoring
// shift-subtract for divide (divide path present only with HILO_DIV_EN).
module hilo_iter
  import hilo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] acc_hi_d,
  output logic [WIDTH-1:0] acc_lo_d
);

  logic [WIDTH:0] sum;

  // {acc_hi, acc_lo} holds the partial product with the multiplier in acc_lo
  always_comb begin
    sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, m}) : {1'b0, acc_hi};
  end

`ifdef HILO_DIV_EN
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in
  always_comb begin
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, m};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_hi_d = diff[WIDTH-1:0];
        acc_lo_d = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_d = shifted[WIDTH-1:0];
        acc_lo_d = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_d = sum[WIDTH:1];
      acc_lo_d = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div;

  always_comb begin
    acc_hi_d = sum[WIDTH:1];
    acc_lo_d = {sum[0], acc_lo[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/hilo_seq.sv
// Iterative HI/LO multiply/divide unit with MTHI/MTLO, pipeline stall and abort.
// Divide ops are built only when HILO_DIV_EN is defined; otherwise they are ignored.
module hilo_seq
  import hilo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] m_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic [WIDTH-1:0] acc_hi_d;
  logic [WIDTH-1:0] acc_lo_d;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic             signed_op;
  logic             is_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             op_ok;
  logic             mt_wr;
  logic             load_en;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign a_s       = src_a;
  assign b_s       = src_b;
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign a_neg     = signed_op && (a_s < 0);
  assign b_neg     = signed_op && (b_s < 0);
  assign a_mag     = cond_neg(src_a, a_neg);
  assign b_mag     = cond_neg(src_b, b_neg);
  assign mt_wr     = mthi | mtlo;
`ifdef HILO_DIV_EN
  assign op_ok     = 1'b1;
`else
  assign op_ok     = !is_div;
`endif
  assign load_en   = (state_q == ST_IDLE) && start && op_ok && !mt_wr;

  // ---- operand capture / iteration stage ----
  hilo_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div   (is_div_q),
    .m        (m_q),
    .acc_hi   (acc_hi_q),
    .acc_lo   (acc_lo_q),
    .acc_hi_d (acc_hi_d),
    .acc_lo_d (acc_lo_d)
  );

  always_ff @(posedge clk) begin
    if (load_en) begin
      acc_hi_q  <= '0;
      acc_lo_q  <= is_div ? a_mag : b_mag;
      m_q       <= is_div ? b_mag : a_mag;
      is_div_q  <= is_div;
      neg_res_q <= a_neg ^ b_neg;
    end else if (state_q == ST_RUN) begin
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
    end
  end

`ifdef HILO_DIV_EN
  logic [WIDTH-1:0] a_q;
  logic             div0_q;
  logic             neg_rem_q;

  always_ff @(posedge clk) begin
    if (load_en) begin
      a_q       <= src_a;
      div0_q    <= (src_b == '0);
      neg_rem_q <= a_neg;
    end
  end
`endif

  // ---- sign correction applied in DONE ----
  always_comb begin
    prod   = cond_neg2({acc_hi_q, acc_lo_q}, neg_res_q);
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef HILO_DIV_EN
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = cond_neg(acc_hi_q, neg_rem_q);
        res_lo = cond_neg(acc_lo_q, neg_res_q);
      end
    end
`endif
  end

  // ---- control FSM and architectural HI/LO ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (mt_wr) begin
        if (mthi) hi_q <= wdata;
        if (mtlo) lo_q <= wdata;
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (load_en) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
            end
          end
          ST_RUN: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= ST_DONE;
          end
          ST_DONE: begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = rd_req & busy_q;

endmodule

// File: tb/tb_hilo_seq.sv
// Scoreboard bench for hilo_seq: expected {hi,lo} queued at launch, compared on done.
module tb_hilo_seq;
  import hilo_pkg::*;

  localparam int W = 32;
`ifdef HILO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         mthi = 1'b0;
  logic         mtlo = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         rd_req = 1'b0;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_pass = 0;
  logic [2*W-1:0] sb_q[$];
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;

  hilo_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_req(rd_req),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    longint unsigned ua, ub, uq, urm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (o)
      OP_MULT:  r = sa * sb;
      OP_MULTU: r = ua * ub;
      OP_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          uq  = ua / ub;
          urm = ua % ub;
          r   = {urm[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit rd, input bit restart, input string tag);
    int cyc;
    int stall_bad;
    bit seen;
    logic [63:0] want;
    bit ign;
    ign = !DIV_EN && o[1];
    op = o; src_a = a; src_b = b; start = 1'b1; rd_req = rd;
    if (!ign) sb_q.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
    if (ign) begin
      @(negedge clk);
      chk({tag, "_ign_busy"}, busy, 0);
      chk({tag, "_ign_hilo"}, {hi, lo}, {m_hi, m_lo});
      rd_req = 1'b0;
      return;
    end
    cyc = 0; seen = 0; stall_bad = 0;
    while (1) begin
      @(negedge clk);
      if (stall !== (rd && cyc <= W)) stall_bad++;
      if (done === 1'b1) begin seen = 1; break; end
      if (cyc >= 40) break;
      if (restart && cyc == 4) begin
        start = 1'b1; op = OP_MULTU; src_a = 32'h1234_5678; src_b = 32'h0000_0100;
      end else start = 1'b0;
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, W + 1);
    want = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    if (seen) begin
      chk({tag, "_hilo"}, {hi, lo}, want);
      m_hi = want[63:32];
      m_lo = want[31:0];
    end
    if (rd) chk({tag, "_stall_pattern"}, stall_bad, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {busy, done}, 2'b00);
    rd_req = 1'b0;
  endtask

  task automatic mt_write(input bit wh, input bit wl, input logic [31:0] d, input bit with_start,
                          input string tag);
    int dn;
    @(negedge clk);
    mthi = wh; mtlo = wl; wdata = d; start = with_start;
    op = OP_MULTU; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk);
    #1 mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    chk({tag, "_quiet"}, dn, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    int          cyc;
    int          dn;

    // reset state
    #1 rst_n = 1'b0;
    rd_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, stall, done}, 3'b000);
    chk("reset_hilo", {hi, lo}, 64'h0);
    rst_n = 1'b1;
    rd_req = 1'b0;
    @(negedge clk);

    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1, 1, "mult_neg");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0, "multu_max");
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0, "mult_minmin");
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 0, 0, "div_neg");
    run_op(OP_DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 0, 0, "divu_zero");
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0, "div_ovf");
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 0, "div_negdiv");
    run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF, 1, 0, "div_zero_neg");

    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 2) ? 32'd0 : $urandom;
      run_op(o, a, b, model(o, a, b), 0, 0, "rand");
    end

    mt_write(1, 1, 32'h0000_CAFE, 0, "mt_both");
    mt_write(1, 0, 32'h0BAD_F00D, 1, "mthi_start");

    // mtlo lands on the tenth RUN edge and must abort the multiply
    op = OP_MULTU; src_a = 32'd100; src_b = 32'd200; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 9; k++) @(posedge clk);
    @(negedge clk);
    mtlo = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk);
    #1 mtlo = 1'b0;
    m_lo = 32'h0000_1234;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi, lo}, {m_hi, m_lo});
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("abort_no_done", dn, 0);

    // asynchronous reset in the middle of RUN
    op = OP_MULTU; src_a = 32'd11; src_b = 32'd13; start = 1'b1; rd_req = 1'b1;
    sb_q.push_back(64'd143);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 16; k++) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    chk("rst_mid_outs", {busy, stall, done}, 3'b000);
    chk("rst_mid_hilo", {hi, lo}, 64'h0);
    rd_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) cyc++;
    end
    chk("rst_mid_quiet", cyc, 0);
    run_op(OP_MULT, 32'd2, 32'd3, 64'd6, 0, 0, "post_rst_mult");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hilo_seq.md
HILO_SEQ -- requirements
Module: hilo_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port: start  input  1  launch operation from op/src_a/src_b.
REQ-005 SHALL have port: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port: src_a  input  WIDTH  rs operand (multiplicand/dividend).
REQ-007 SHALL have port: src_b  input  WIDTH  rt operand (multiplier/divisor).
REQ-008 SHALL have port: mthi / mtlo  input  1 each  write wdata into HI / LO.
REQ-009 SHALL have port: wdata  input  WIDTH  MTHI/MTLO data.
REQ-010 SHALL have port: rd_req  input  1  MFHI/MFLO in decode this cycle.
REQ-011 SHALL have port: busy  output  1  operation in progress.
REQ-012 SHALL have port: stall  output  1  freeze fetch/decode.
REQ-013 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-014 SHALL have port: hi / lo  output  WIDTH each  architectural HI/LO.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 IDLE: start (without mthi/mtlo) SHALL capture operands and enter RUN next edge.
REQ-017 RUN SHALL last exactly WIDTH cycles, one radix-2 shift-add (mult) or restoring shift-subtract (div) step per cycle, then enter DONE.
REQ-018 DONE SHALL last one cycle, assert done, load hi/lo that edge, and return to IDLE.
REQ-019 Latency: start sampled at edge N; hi/lo valid and done high after edge N+WIDTH+1.
REQ-020 busy SHALL be high in RUN and DONE, low in IDLE.
REQ-021 stall SHALL equal rd_req AND busy; rd_req while IDLE SHALL not stall.
REQ-022 MULT/MULTU: {hi,lo} = full 2*WIDTH product; MULT signed, MULTU unsigned.
REQ-023 DIV/DIVU: lo = quotient, hi = remainder; signed DIV truncates toward zero, remainder takes dividend sign.
REQ-024 Signed ops SHALL iterate on magnitudes and apply sign correction in DONE.
REQ-025 Divide by zero: hi = src_a, lo = all ones, same latency, no error flag.
REQ-026 DIV of most-negative by -1: lo = 0x80000000, hi = 0.
REQ-027 start while busy SHALL be ignored.
REQ-028 mthi/mtlo while busy SHALL abort the operation (return to IDLE next edge, no done) and perform the write.
REQ-029 mthi/mtlo with start in same cycle: write performed, start ignored.
REQ-030 mthi and mtlo together SHALL write both registers with wdata.

Reset
REQ-031 rst_n low SHALL force IDLE, hi = 0, lo = 0, busy = 0, stall = 0, done = 0, including mid-RUN.

Configuration
REQ-032 With HILO_DIV_EN defined, divide ops SHALL function per REQ-023..026.
REQ-033 Without HILO_DIV_EN, start with op[1]=1 SHALL be ignored (no busy, hi/lo unchanged) and divide logic SHALL be absent.

Structure
REQ-034 Package hilo_pkg SHALL hold op encodings, FSM state typedef, and WIDTH default.
REQ-035 Per-step add/subtract-shift datapath SHALL be sub-module hilo_iter; hilo_seq holds FSM, counter, HI/LO.

Verification
REQ-036 MULT src_a=-3, src_b=7 -> after 33 cycles done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 5/0 -> hi=5, lo=0xFFFFFFFF.
REQ-039 rd_req held during MULT -> stall high cycles 1..33, low after done; second start at cycle 5 ignored.
REQ-040 mtlo wdata=0x1234 at RUN cycle 10 -> no done, lo=0x1234, hi unchanged, busy low next cycle.
REQ-041 rst_n low at RUN cycle 16 -> hi=lo=0, busy=0 immediately; new MULT 2*3 afterwards -> lo=6.
